// File: rtl/pe_host_pkg.sv
// rtl/pe_host_pkg.sv - register map, control/status bit positions and run-control states
package pe_host_pkg;

    localparam logic [2:0] REG_CTRL      = 3'd0;
    localparam logic [2:0] REG_STATUS    = 3'd1;
    localparam logic [2:0] REG_IMEM_ADDR = 3'd2;
    localparam logic [2:0] REG_IMEM_DATA = 3'd3;
    localparam logic [2:0] REG_RUN_LEN   = 3'd4;
    localparam logic [2:0] REG_OUT_COUNT = 3'd5;
    localparam logic [2:0] REG_OUT_PTR   = 3'd6;
    localparam logic [2:0] REG_OUT_DATA  = 3'd7;

    localparam int CTRL_START  = 0;
    localparam int CTRL_STOP   = 1;
    localparam int CTRL_IRQ_EN = 2;
    localparam int CTRL_CLEAR  = 3;

    localparam int STAT_DONE     = 2;
    localparam int STAT_OVF      = 3;
    localparam int STAT_IRQ      = 4;
    localparam int STAT_IMEM_ERR = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/pe_host_bridge_if.sv
// rtl/pe_host_bridge_if.sv - host slave bus bundle between SoC master and the bridge
interface pe_host_bridge_if #(
    parameter int DataWidth = 32
);
    logic                 iChipSelect_n;
    logic                 iWrite_n;
    logic                 iRead_n;
    logic [2:0]           iAddress;
    logic [DataWidth-1:0] iData;
    logic [DataWidth-1:0] oData;
    logic                 oReadValid;

    modport master (
        output iChipSelect_n, iWrite_n, iRead_n, iAddress, iData,
        input  oData, oReadValid
    );

    modport slave (
        input  iChipSelect_n, iWrite_n, iRead_n, iAddress, iData,
        output oData, oReadValid
    );
endinterface

// File: rtl/pe_host_lane_packer.sv
// rtl/pe_host_lane_packer.sv - assembles Lanes host words into one instruction word
module pe_host_lane_packer #(
    parameter int Lanes     = 4,
    parameter int DataWidth = 32
) (
    input  logic                       iClk,
    input  logic                       iReset_n,
    input  logic                       i_clear,
    input  logic                       i_wr_en,
    input  logic [DataWidth-1:0]       i_data,
    output logic                       o_commit,
    output logic [Lanes*DataWidth-1:0] o_word
);
    localparam int LaneBits = $clog2(Lanes);

    logic [LaneBits-1:0]        r_lane;
    logic [Lanes*DataWidth-1:0] r_word;
    logic                       r_commit;

    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            r_lane   <= '0;
            r_word   <= '0;
            r_commit <= 1'b0;
        end else begin
            r_commit <= 1'b0;
            if (i_clear) begin
                r_lane <= '0;
            end else if (i_wr_en) begin
                r_word[int'(r_lane)*DataWidth +: DataWidth] <= i_data;
                // Lanes is a power of two, so the counter wraps back to lane 0 by itself
                r_lane <= r_lane + LaneBits'(1);
                if (r_lane == LaneBits'(Lanes - 1))
                    r_commit <= 1'b1;
            end
        end
    end

    assign o_commit = r_commit;
    assign o_word   = r_word;
endmodule

// File: rtl/pe_host_bridge.sv
// rtl/pe_host_bridge.sv - host bridge: instruction packing, PE run control, output capture and readback
module pe_host_bridge
    import pe_host_pkg::*;
#(
    parameter int DataWidth     = 32,
    parameter int Lanes         = 4,
    parameter int ImemAddrWidth = 10,
    parameter int OutAddrWidth  = 10
) (
    input  logic                       iClk,
    input  logic                       iReset_n,
    pe_host_bridge_if.slave            bus,
    output logic                       oIrq,
    output logic                       oPeRst_n,
    output logic                       oImemWrEn,
    output logic [ImemAddrWidth-1:0]   oImemWrAddr,
    output logic [Lanes*DataWidth-1:0] oImemWrData,
    input  logic [Lanes*DataWidth-1:0] iPeData,
    input  logic [Lanes-1:0]           iPeReady,
    output logic                       oBufWrEn,
    output logic [OutAddrWidth-1:0]    oBufWrAddr,
    output logic [Lanes*DataWidth-1:0] oBufWrData,
    output logic [OutAddrWidth-1:0]    oBufRdAddr,
    input  logic [Lanes*DataWidth-1:0] iBufRdData
);
    localparam int LaneBits = $clog2(Lanes);
    localparam int PtrWidth = OutAddrWidth + LaneBits;
    localparam logic [OutAddrWidth:0] DepthCnt = {1'b1, {OutAddrWidth{1'b0}}};

    state_e                     r_state, w_state_next;
    logic [ImemAddrWidth-1:0]   r_imem_addr;
    logic [OutAddrWidth:0]      r_run_len, r_out_count;
    logic [PtrWidth-1:0]        r_out_ptr;
    logic                       r_irq_en, r_done, r_overflow, r_irq_pend, r_imem_err;
    logic                       r_buf_wr_en;
    logic [OutAddrWidth-1:0]    r_buf_wr_addr;
    logic [Lanes*DataWidth-1:0] r_buf_wr_data;
    logic                       r_rd_pend, r_rd_is_out, r_rd_valid;
    logic [LaneBits-1:0]        r_rd_lane;
    logic [DataWidth-1:0]       r_rd_word, r_rd_data, w_rd_word;

    logic w_wr, w_rd, w_ctrl_wr, w_start, w_stop, w_clear;
    logic w_in_run, w_imem_wr, w_imem_addr_wr, w_imem_blocked;
    logic w_beat, w_full, w_capture, w_ovf, w_limit, w_enter_run, w_enter_done;
    logic w_commit;
    logic [OutAddrWidth:0] w_count_inc;

    assign w_wr      = !bus.iChipSelect_n && !bus.iWrite_n;
    assign w_rd      = !bus.iChipSelect_n && !bus.iRead_n;
    assign w_ctrl_wr = w_wr && (bus.iAddress == REG_CTRL);
    assign w_start   = w_ctrl_wr && bus.iData[CTRL_START];
    assign w_stop    = w_ctrl_wr && bus.iData[CTRL_STOP];
    assign w_clear   = w_ctrl_wr && bus.iData[CTRL_CLEAR];
    assign w_in_run  = (r_state == ST_RUN);

    assign w_imem_wr      = w_wr && (bus.iAddress == REG_IMEM_DATA);
    assign w_imem_addr_wr = w_wr && (bus.iAddress == REG_IMEM_ADDR);
    assign w_imem_blocked = w_in_run && (w_imem_wr || w_imem_addr_wr);

    assign w_beat      = w_in_run && (&iPeReady);
    assign w_full      = (r_out_count == DepthCnt);
    assign w_count_inc = r_out_count + (OutAddrWidth + 1)'(1);
    assign w_capture   = w_beat && !w_full && !w_clear;
    assign w_ovf       = w_beat && w_full && !w_clear;
    assign w_limit     = w_capture && (r_run_len != '0) && (w_count_inc == r_run_len);

    always_comb begin
        w_state_next = r_state;
        if (w_clear) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: if (w_start) w_state_next = ST_RUN;
                ST_RUN:           if (w_stop || w_limit || w_ovf) w_state_next = ST_DONE;
                default:          w_state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) r_state <= ST_IDLE;
        else           r_state <= w_state_next;
    end

    assign w_enter_run  = (w_state_next == ST_RUN)  && (r_state != ST_RUN);
    assign w_enter_done = (w_state_next == ST_DONE) && (r_state != ST_DONE);

    pe_host_lane_packer #(.Lanes(Lanes), .DataWidth(DataWidth)) u_packer (
        .iClk     (iClk),
        .iReset_n (iReset_n),
        .i_clear  ((w_imem_addr_wr && !w_in_run) || w_clear),
        .i_wr_en  (w_imem_wr && !w_in_run),
        .i_data   (bus.iData),
        .o_commit (w_commit),
        .o_word   (oImemWrData)
    );

    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            r_imem_addr   <= '0;
            r_run_len     <= '0;
            r_out_count   <= '0;
            r_out_ptr     <= '0;
            r_irq_en      <= 1'b0;
            r_done        <= 1'b0;
            r_overflow    <= 1'b0;
            r_irq_pend    <= 1'b0;
            r_imem_err    <= 1'b0;
            r_buf_wr_en   <= 1'b0;
            r_buf_wr_addr <= '0;
            r_buf_wr_data <= '0;
        end else begin
            r_buf_wr_en <= w_capture;
            if (w_capture) begin
                r_buf_wr_addr <= r_out_count[OutAddrWidth-1:0];
                r_buf_wr_data <= iPeData;
                r_out_count   <= w_count_inc;
            end
            if (w_ctrl_wr)
                r_irq_en <= bus.iData[CTRL_IRQ_EN];
            if (w_wr && (bus.iAddress == REG_RUN_LEN))
                r_run_len <= bus.iData[OutAddrWidth:0];
            if (w_wr && (bus.iAddress == REG_STATUS)) begin
                if (bus.iData[STAT_IRQ])      r_irq_pend <= 1'b0;
                if (bus.iData[STAT_IMEM_ERR]) r_imem_err <= 1'b0;
            end
            if (w_imem_blocked) r_imem_err <= 1'b1;
            if (w_ovf)          r_overflow <= 1'b1;
            if (w_enter_run) begin
                r_out_count <= '0;
                r_done      <= 1'b0;
                r_overflow  <= 1'b0;
            end
            if (w_enter_done) begin
                r_done <= 1'b1;
                if (r_irq_en) r_irq_pend <= 1'b1;
            end
            // The commit pulse is already on the port, so the address advances behind it
            if (w_imem_addr_wr && !w_in_run)
                r_imem_addr <= bus.iData[ImemAddrWidth-1:0];
            else if (w_commit)
                r_imem_addr <= r_imem_addr + ImemAddrWidth'(1);
            if (w_wr && (bus.iAddress == REG_OUT_PTR))
                r_out_ptr <= bus.iData[PtrWidth-1:0];
            else if (w_rd && (bus.iAddress == REG_OUT_DATA))
                r_out_ptr <= r_out_ptr + PtrWidth'(1);
            if (w_clear) begin
                r_out_count <= '0;
                r_out_ptr   <= '0;
                r_done      <= 1'b0;
                r_overflow  <= 1'b0;
                r_irq_pend  <= 1'b0;
                r_imem_err  <= 1'b0;
            end
        end
    end

    always_comb begin
        w_rd_word = '0;
        case (bus.iAddress)
            REG_STATUS:    w_rd_word = DataWidth'({r_imem_err, r_irq_pend, r_overflow, r_done, r_state});
            REG_IMEM_ADDR: w_rd_word = DataWidth'(r_imem_addr);
            REG_RUN_LEN:   w_rd_word = DataWidth'(r_run_len);
            REG_OUT_COUNT: w_rd_word = DataWidth'(r_out_count);
            default:       w_rd_word = '0;
        endcase
    end

    // Two-stage read path: every register waits one stage so OUT_DATA's buffer latency is hidden
    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            r_rd_pend   <= 1'b0;
            r_rd_is_out <= 1'b0;
            r_rd_lane   <= '0;
            r_rd_word   <= '0;
            r_rd_valid  <= 1'b0;
            r_rd_data   <= '0;
        end else begin
            r_rd_pend <= w_rd;
            if (w_rd) begin
                r_rd_is_out <= (bus.iAddress == REG_OUT_DATA);
                r_rd_lane   <= r_out_ptr[LaneBits-1:0];
                r_rd_word   <= w_rd_word;
            end
            r_rd_valid <= r_rd_pend;
            if (r_rd_pend)
                r_rd_data <= r_rd_is_out ? iBufRdData[int'(r_rd_lane)*DataWidth +: DataWidth] : r_rd_word;
        end
    end

    assign bus.oData      = r_rd_data;
    assign bus.oReadValid = r_rd_valid;
    assign oIrq           = r_irq_pend;
    assign oPeRst_n       = w_in_run;
    assign oImemWrEn      = w_commit;
    assign oImemWrAddr    = r_imem_addr;
    assign oBufWrEn       = r_buf_wr_en;
    assign oBufWrAddr     = r_buf_wr_addr;
    assign oBufWrData     = r_buf_wr_data;
    assign oBufRdAddr     = r_out_ptr[PtrWidth-1:LaneBits];
endmodule

// File: tb/tb_pe_host_bridge.sv
// tb/tb_pe_host_bridge.sv - directed self-checking bench for pe_host_bridge
module tb_pe_host_bridge;
    import pe_host_pkg::*;

    localparam int DW  = 32;
    localparam int L   = 4;
    localparam int IAW = 3;
    localparam int OAW = 2;

    logic iClk = 1'b0;
    logic iReset_n = 1'b0;
    always #5 iClk = ~iClk;

    pe_host_bridge_if #(.DataWidth(DW)) bus ();

    logic             oIrq, oPeRst_n, oImemWrEn, oBufWrEn;
    logic [IAW-1:0]   oImemWrAddr;
    logic [L*DW-1:0]  oImemWrData, oBufWrData, iPeData, iBufRdData;
    logic [L-1:0]     iPeReady;
    logic [OAW-1:0]   oBufWrAddr, oBufRdAddr;

    pe_host_bridge #(.DataWidth(DW), .Lanes(L), .ImemAddrWidth(IAW), .OutAddrWidth(OAW)) dut (
        .iClk        (iClk),
        .iReset_n    (iReset_n),
        .bus         (bus),
        .oIrq        (oIrq),
        .oPeRst_n    (oPeRst_n),
        .oImemWrEn   (oImemWrEn),
        .oImemWrAddr (oImemWrAddr),
        .oImemWrData (oImemWrData),
        .iPeData     (iPeData),
        .iPeReady    (iPeReady),
        .oBufWrEn    (oBufWrEn),
        .oBufWrAddr  (oBufWrAddr),
        .oBufWrData  (oBufWrData),
        .oBufRdAddr  (oBufRdAddr),
        .iBufRdData  (iBufRdData)
    );

    logic [L*DW-1:0] mem [0:(1<<OAW)-1];
    int imem_cnt = 0;
    int buf_cnt  = 0;
    int checks   = 0;
    int errors   = 0;

    initial begin
        for (int i = 0; i < (1 << OAW); i++) mem[i] = '0;
        iBufRdData = '0;
    end

    always @(posedge iClk) begin
        if (oBufWrEn) mem[oBufWrAddr] <= oBufWrData;
        iBufRdData <= mem[oBufRdAddr];
    end

    always @(negedge iClk) begin
        if (oImemWrEn) imem_cnt++;
        if (oBufWrEn)  buf_cnt++;
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [L*DW-1:0] pack(input logic [31:0] base, input int k);
        logic [L*DW-1:0] v;
        for (int l = 0; l < L; l++) v[l*DW +: DW] = base + 32'(k*16 + l);
        return v;
    endfunction

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge iClk);
        bus.iChipSelect_n = 1'b0; bus.iWrite_n = 1'b0; bus.iAddress = a; bus.iData = d;
        @(negedge iClk);
        bus.iChipSelect_n = 1'b1; bus.iWrite_n = 1'b1;
    endtask

    task automatic read_chk(input string tag, input logic [2:0] a, input logic [31:0] exp);
        @(negedge iClk);
        bus.iChipSelect_n = 1'b0; bus.iRead_n = 1'b0; bus.iAddress = a;
        @(negedge iClk);
        bus.iChipSelect_n = 1'b1; bus.iRead_n = 1'b1;
        @(negedge iClk);
        check({tag, "_valid"}, bus.oReadValid, 1'b1);
        check(tag, bus.oData, exp);
    endtask

    task automatic drive_beats(input int n, input logic [31:0] base);
        for (int k = 0; k < n; k++) begin
            @(negedge iClk);
            iPeReady = '1; iPeData = pack(base, k);
        end
        @(negedge iClk);
        iPeReady = '0;
        repeat (2) @(negedge iClk);
    endtask

    initial begin
        int b0, i0;
        bus.iChipSelect_n = 1'b1; bus.iWrite_n = 1'b1; bus.iRead_n = 1'b1;
        bus.iAddress = '0; bus.iData = '0;
        iPeReady = '0; iPeData = '0;
        repeat (3) @(negedge iClk);
        check("rst_pe_rst_n", oPeRst_n, 1'b0);
        check("rst_irq", oIrq, 1'b0);
        check("rst_imem_wr", oImemWrEn, 1'b0);
        check("rst_buf_wr", oBufWrEn, 1'b0);
        check("rst_rd_valid", bus.oReadValid, 1'b0);
        check("rst_odata", bus.oData, 32'h0);
        iReset_n = 1'b1;
        read_chk("rst_status", REG_STATUS, 32'h0);

        // instruction packing
        bus_write(REG_IMEM_ADDR, 32'd5);
        for (int i = 0; i < 4; i++) begin
            bus_write(REG_IMEM_DATA, 32'h11 * (i + 1));
            check("imem_pulse_timing", oImemWrEn, (i == 3));
        end
        check("imem_addr_out", oImemWrAddr, 3'd5);
        check("imem_data_out", oImemWrData, 128'h00000044_00000033_00000022_00000011);
        @(negedge iClk);
        check("imem_pulse_one_cycle", oImemWrEn, 1'b0);
        read_chk("imem_addr_inc", REG_IMEM_ADDR, 32'd6);

        // lane reset on IMEM_ADDR write, then address wrap
        bus_write(REG_IMEM_ADDR, 32'd7);
        bus_write(REG_IMEM_DATA, 32'hDEAD);
        bus_write(REG_IMEM_ADDR, 32'd7);
        for (int i = 0; i < 4; i++) bus_write(REG_IMEM_DATA, 32'hA0 + i);
        check("wrap_pulse", oImemWrEn, 1'b1);
        check("wrap_addr_out", oImemWrAddr, 3'd7);
        check("wrap_data_out", oImemWrData, 128'h000000A3_000000A2_000000A1_000000A0);
        read_chk("wrap_imem_addr", REG_IMEM_ADDR, 32'd0);

        // RUN_LEN limit
        bus_write(REG_RUN_LEN, 32'd3);
        bus_write(REG_CTRL, 32'h1);
        check("start_pe_rst_n", oPeRst_n, 1'b1);
        b0 = buf_cnt;
        drive_beats(4, 32'hB000_0000);
        check("len_buf_writes", buf_cnt - b0, 3);
        check("len_mem0", mem[0], pack(32'hB000_0000, 0));
        check("len_mem1", mem[1], pack(32'hB000_0000, 1));
        check("len_mem2", mem[2], pack(32'hB000_0000, 2));
        check("len_mem3", mem[3], 128'h0);
        check("len_pe_rst_n", oPeRst_n, 1'b0);
        read_chk("len_status", REG_STATUS, 32'h6);
        read_chk("len_out_count", REG_OUT_COUNT, 32'd3);
        read_chk("len_run_len", REG_RUN_LEN, 32'd3);

        // overflow with unlimited run length
        bus_write(REG_RUN_LEN, 32'd0);
        bus_write(REG_CTRL, 32'h1);
        b0 = buf_cnt;
        drive_beats(5, 32'hC000_0000);
        check("ovf_buf_writes", buf_cnt - b0, 4);
        check("ovf_mem3", mem[3], pack(32'hC000_0000, 3));
        read_chk("ovf_status", REG_STATUS, 32'hE);
        read_chk("ovf_out_count", REG_OUT_COUNT, 32'd4);

        // back-to-back OUT_DATA readback of beat 1
        bus_write(REG_OUT_PTR, 32'd4);
        @(negedge iClk);
        bus.iChipSelect_n = 1'b0; bus.iRead_n = 1'b0; bus.iAddress = REG_OUT_DATA;
        for (int i = 0; i < 6; i++) begin
            @(negedge iClk);
            if (i == 3) begin bus.iChipSelect_n = 1'b1; bus.iRead_n = 1'b1; end
            if (i == 0 || i == 5) begin
                check("b2b_valid_low", bus.oReadValid, 1'b0);
            end else begin
                check("b2b_valid", bus.oReadValid, 1'b1);
                check("b2b_data", bus.oData, 32'hC000_0010 + 32'(i - 1));
            end
        end
        bus_write(REG_OUT_PTR, 32'd15);
        read_chk("ptr_last_lane", REG_OUT_DATA, 32'hC000_0033);
        read_chk("ptr_wrap", REG_OUT_DATA, 32'hC000_0000);
        read_chk("wo_ctrl_zero", REG_CTRL, 32'h0);

        // interrupt and W1C
        bus_write(REG_RUN_LEN, 32'd2);
        bus_write(REG_CTRL, 32'h5);
        drive_beats(2, 32'hD000_0000);
        check("irq_set", oIrq, 1'b1);
        read_chk("irq_status", REG_STATUS, 32'h16);
        bus_write(REG_STATUS, 32'h10);
        check("irq_w1c", oIrq, 1'b0);
        read_chk("irq_status_after", REG_STATUS, 32'h6);

        // stop and beat in the same cycle
        bus_write(REG_RUN_LEN, 32'd0);
        bus_write(REG_CTRL, 32'h1);
        @(negedge iClk);
        bus.iChipSelect_n = 1'b0; bus.iWrite_n = 1'b0; bus.iAddress = REG_CTRL; bus.iData = 32'h2;
        iPeReady = '1; iPeData = pack(32'hE000_0000, 0);
        @(negedge iClk);
        bus.iChipSelect_n = 1'b1; bus.iWrite_n = 1'b1; iPeReady = '0;
        check("stop_beat_wr", oBufWrEn, 1'b1);
        check("stop_beat_addr", oBufWrAddr, 2'd0);
        check("stop_pe_rst_n", oPeRst_n, 1'b0);
        read_chk("stop_out_count", REG_OUT_COUNT, 32'd1);

        // IMEM access during RUN, then start+clear
        bus_write(REG_CTRL, 32'h1);
        i0 = imem_cnt;
        bus_write(REG_IMEM_ADDR, 32'd3);
        for (int i = 0; i < 4; i++) bus_write(REG_IMEM_DATA, 32'h55);
        repeat (2) @(negedge iClk);
        check("run_imem_dropped", imem_cnt - i0, 0);
        read_chk("run_imem_err", REG_STATUS, 32'h21);
        read_chk("run_imem_addr", REG_IMEM_ADDR, 32'd0);
        bus_write(REG_CTRL, 32'h9);
        check("clear_pe_rst_n", oPeRst_n, 1'b0);
        read_chk("clear_status", REG_STATUS, 32'h0);
        read_chk("clear_out_count", REG_OUT_COUNT, 32'd0);

        // asynchronous reset mid-run drops the partial instruction
        bus_write(REG_IMEM_DATA, 32'h99);
        bus_write(REG_CTRL, 32'h1);
        check("mid_run", oPeRst_n, 1'b1);
        #2 iReset_n = 1'b0;
        #1 check("async_pe_rst", oPeRst_n, 1'b0);
        @(negedge iClk);
        iReset_n = 1'b1;
        for (int i = 0; i < 4; i++) bus_write(REG_IMEM_DATA, 32'hF1 + i);
        check("post_rst_pulse", oImemWrEn, 1'b1);
        check("post_rst_addr", oImemWrAddr, 3'd0);
        check("post_rst_data", oImemWrData, 128'h000000F4_000000F3_000000F2_000000F1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pe_host_bridge.md
# pe_host_bridge

Memory-mapped host bridge between the 32-bit SoC slave bus and one PE shader core. It packs 32-bit host writes into Lanes-wide instructions for instruction memory and sequences PE reset/run through a run-control FSM. It captures PE output beats into an external output buffer with overflow detection and serves buffered results back to the host word by word with auto-increment.

## Interface
- DataWidth, 32, bus and lane word width
- Lanes, 4, words per instruction and per output beat (power of 2, ≥2)
- ImemAddrWidth, 10, instruction memory address width
- OutAddrWidth, 10, output buffer beat address width; depth = 2**OutAddrWidth
- iClk  in  1  clock
- iReset_n  in  1  reset, asynchronous, active-low
- iChipSelect_n, iWrite_n, iRead_n  in  1 each  bus strobes, active-low
- iAddress  in  3  register word index
- iData  in  DataWidth  write data
- oData  out  DataWidth  read data, registered
- oReadValid  out  1  read data qualifier
- oIrq  out  1  done interrupt
- oPeRst_n  out  1  PE reset, low = held
- oImemWrEn  out  1  instruction write pulse
- oImemWrAddr  out  ImemAddrWidth  instruction address
- oImemWrData  out  Lanes*DataWidth  packed instruction, lane 0 in LSBs
- iPeData  in  Lanes*DataWidth  PE output beat
- iPeReady  in  Lanes  per-lane ready; beat valid when all set
- oBufWrEn, oBufWrAddr (OutAddrWidth), oBufWrData (Lanes*DataWidth)  out  buffer write port
- oBufRdAddr  out  OutAddrWidth  buffer read address; iBufRdData  in  Lanes*DataWidth, 1-cycle latency

## Operation
- Registers: 0 CTRL (W): bit0 start, bit1 stop, bit2 irq_en, bit3 clear. 1 STATUS (R): [1:0] state, bit2 done, bit3 overflow, bit4 irq_pend, bit5 imem_err; W1C on bits 4 and 5. 2 IMEM_ADDR (R/W). 3 IMEM_DATA (W). 4 RUN_LEN (R/W, OutAddrWidth+1 bits; 0 = unlimited). 5 OUT_COUNT (R). 6 OUT_PTR (W): {beat, lane}. 7 OUT_DATA (R).
- Writes take effect when iChipSelect_n=0 and iWrite_n=0. Unmapped bits are ignored; reads of write-only registers return 0.
- IMEM_DATA writes fill a lane counter 0..Lanes-1. The last lane write produces a one-cycle oImemWrEn with the full packed word, then IMEM_ADDR increments and wraps at 2**ImemAddrWidth. Writing IMEM_ADDR resets the lane counter.
- FSM states: IDLE (0), RUN (1), DONE (2).
  - IDLE or DONE + start: go to RUN; OUT_COUNT, done and overflow clear.
  - RUN + stop, count reaching RUN_LEN, or overflow: go to DONE.
  - clear in any state: go to IDLE, clearing counters and flags.
- oPeRst_n = 1 only in RUN.
- In RUN, IMEM_DATA or IMEM_ADDR writes are dropped and set imem_err.
- Capture happens in RUN when &iPeReady:
  - count < depth: write the beat at address OUT_COUNT, then increment.
  - count == depth: drop the beat, set overflow, go to DONE.
- A beat coinciding with the count reaching RUN_LEN is written, then the FSM goes to DONE.
- On entry to DONE: done=1; irq_pend=1 if irq_en. oIrq = irq_pend.
- OUT_DATA returns the lane selected by OUT_PTR, then OUT_PTR auto-increments. The beat wraps at depth.

## Timing
- Reset values: all outputs 0; state IDLE; lane counter, IMEM_ADDR, RUN_LEN, OUT_COUNT, OUT_PTR and all flags 0.
- oImemWrEn asserts the cycle after the last-lane write.
- Read: strobe at cycle T gives oData/oReadValid at T+2 for every register, uniform latency. oData holds its last value otherwise. Back-to-back OUT_DATA reads every cycle are supported.
- Start write at T gives RUN and oPeRst_n=1 at T+1.
- A beat sampled at T gives oBufWrEn at T+1. DONE is entered at T+1 when the limit is hit.
- Stop and a beat in the same cycle: the beat is captured.
- Start and clear in the same write: clear wins.
- Asynchronous reset mid-run: PE is reset immediately and the pending lane assembly is lost.

## Structure
- Package pe_host_pkg holds:
  - register index localparams
  - CTRL/STATUS bit positions
  - state enum (IDLE, RUN, DONE)
- Sub-module pe_host_lane_packer (Lanes, DataWidth) contains the lane counter, shift/assembly register and commit pulse.
- The FSM, capture counter and read path stay in the top level.

## Test plan
- Write IMEM_ADDR=5, then IMEM_DATA 0x11,0x22,0x33,0x44 → one oImemWrEn at addr 5 with data 0x00000044_00000033_00000022_00000011; IMEM_ADDR reads 6.
- RUN_LEN=3, start, drive 4 ready beats → 3 buffer writes at 0,1,2; STATUS state=DONE, done=1; oPeRst_n=0; OUT_COUNT=3.
- OutAddrWidth=2, RUN_LEN=0, 5 beats → 4 written, overflow=1, DONE.
- irq_en=1 run to completion → oIrq=1; write STATUS bit4 → oIrq=0.
- OUT_PTR=4 (beat 1, lane 0), 4 OUT_DATA reads → lanes 0..3 of beat 1, oReadValid at T+2 each.
- IMEM_DATA write during RUN → no oImemWrEn, imem_err=1; clear → IDLE, flags 0.
